// File: rtl/tlul_sram_responder.sv
// TL-UL device-side adapter in front of a single-port SRAM with a
// request/grant handshake and in-order read-data return.
// Accepted requests are queued in reqfifo. Read data is queued in rspfifo.
// D responses are built combinationally from the two FIFO heads, so they stay
// stable while the host stalls.
module tlul_sram_responder #(
  parameter int SramAw      = 12,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [101:0]      tl_i,
  output logic [67:0]       tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rerror_i
);
  localparam int PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CW = $clog2(Outstanding + 1);

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_PUTP = 3'd1;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] ACK     = 3'd0;
  localparam logic [2:0] ACKD    = 3'd1;

  // A-channel fields
  logic        w_a_valid;
  logic [2:0]  w_a_opcode;
  logic [1:0]  w_a_size;
  logic [7:0]  w_a_source;
  logic [1:0]  w_a_addr_lo;
  logic [3:0]  w_a_mask;
  logic        w_d_ready;
  logic        w_unused;

  assign w_a_valid   = tl_i[101];
  assign w_a_opcode  = tl_i[100:98];
  assign w_a_size    = tl_i[94:93];
  assign w_a_source  = tl_i[92:85];
  assign w_a_addr_lo = tl_i[54:53];
  assign w_a_mask    = tl_i[52:49];
  assign w_d_ready   = tl_i[0];
  // a_param, a_user and the address bits above the SRAM window are not used.
  assign w_unused    = ^tl_i;

  // Byte lanes covered by the access, given its size and low address bits.
  logic [3:0] w_lane_req;
  // Select the required byte lanes for the access size.
  always_comb begin
    w_lane_req = 4'hF;
    case (w_a_size)
      2'd0:    w_lane_req = 4'b0001 << w_a_addr_lo;
      2'd1:    w_lane_req = w_a_addr_lo[1] ? 4'b1100 : 4'b0011;
      default: w_lane_req = 4'hF;
    endcase
  end

  logic w_op_bad, w_size_bad, w_misalign, w_mask_bad, w_err;
  assign w_op_bad   = !((w_a_opcode == OP_PUTF) || (w_a_opcode == OP_PUTP) ||
                        (w_a_opcode == OP_GET));
  assign w_size_bad = (w_a_size == 2'd3);
  assign w_misalign = ((w_a_size == 2'd1) && w_a_addr_lo[0]) ||
                      ((w_a_size == 2'd2) && (w_a_addr_lo != 2'd0));
  assign w_mask_bad = (w_a_opcode == OP_PUTF) &&
                      ((w_a_mask & w_lane_req) != w_lane_req);
  assign w_err      = w_op_bad | w_size_bad | w_misalign | w_mask_bad;

  // Request FIFO: {opcode[13:11], size[10:9], source[8:1], error[0]}
  logic [13:0]   r_req_mem [Outstanding];
  logic [PW-1:0] r_req_wp, r_req_rp;
  logic [CW-1:0] r_req_cnt;
  // Response FIFO: {rerror[32], rdata[31:0]}
  logic [32:0]   r_rsp_mem [Outstanding];
  logic [PW-1:0] r_rsp_wp, r_rsp_rp;
  logic [CW-1:0] r_rsp_cnt;
  // Reads granted whose data has not come back yet; clearing it on reset is
  // what drops late read data for grants issued before reset.
  logic [CW-1:0] r_pend;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(Outstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  logic w_full, w_req_empty, w_rsp_empty, w_a_ready;
  logic w_req_push, w_req_pop, w_rsp_push, w_rsp_pop, w_rd_grant;
  logic [13:0] w_hd;
  logic [2:0]  w_hd_op;
  logic        w_hd_err, w_hd_read, w_d_valid;
  logic [32:0] w_rsp_hd;

  assign w_full      = (r_req_cnt == CW'(Outstanding));
  assign w_req_empty = (r_req_cnt == '0);
  assign w_rsp_empty = (r_rsp_cnt == '0);

  // No fall-through when full: a pop in the same cycle does not open a_ready.
  assign req_o      = w_a_valid & ~w_err & ~w_full;
  assign w_a_ready  = ~w_full & (w_err | gnt_i);
  assign w_req_push = w_a_valid & w_a_ready;
  assign w_rd_grant = req_o & gnt_i & (w_a_opcode == OP_GET);

  assign we_o    = (w_a_opcode == OP_PUTF) || (w_a_opcode == OP_PUTP);
  assign addr_o  = tl_i[53+SramAw+1:55];
  assign wdata_o = tl_i[48:17];
  assign wmask_o = {{8{w_a_mask[3]}}, {8{w_a_mask[2]}},
                    {8{w_a_mask[1]}}, {8{w_a_mask[0]}}};

  assign w_hd      = r_req_mem[r_req_rp];
  assign w_hd_op   = w_hd[13:11];
  assign w_hd_err  = w_hd[0];
  assign w_hd_read = (w_hd_op == OP_GET) & ~w_hd_err;
  assign w_rsp_hd  = r_rsp_mem[r_rsp_rp];

  assign w_d_valid  = ~w_req_empty & (~w_hd_read | ~w_rsp_empty);
  assign w_req_pop  = w_d_valid & w_d_ready;
  assign w_rsp_pop  = w_req_pop & w_hd_read;
  assign w_rsp_push = rvalid_i & (r_pend != '0);

  // Request FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Outstanding; i++) r_req_mem[i] <= '0;
      r_req_wp  <= '0;
      r_req_rp  <= '0;
      r_req_cnt <= '0;
    end else begin
      if (w_req_push) begin
        r_req_mem[r_req_wp] <= {w_a_opcode, w_a_size, w_a_source, w_err};
        r_req_wp            <= f_inc(r_req_wp);
      end
      if (w_req_pop) r_req_rp <= f_inc(r_req_rp);
      r_req_cnt <= r_req_cnt + CW'(w_req_push) - CW'(w_req_pop);
    end
  end

  // Response FIFO storage, pointers, occupancy and pending-read count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Outstanding; i++) r_rsp_mem[i] <= '0;
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
      r_pend    <= '0;
    end else begin
      if (w_rsp_push) begin
        r_rsp_mem[r_rsp_wp] <= {|rerror_i, rdata_i};
        r_rsp_wp            <= f_inc(r_rsp_wp);
      end
      if (w_rsp_pop) r_rsp_rp <= f_inc(r_rsp_rp);
      r_rsp_cnt <= r_rsp_cnt + CW'(w_rsp_push) - CW'(w_rsp_pop);
      r_pend    <= r_pend + CW'(w_rd_grant) - CW'(w_rsp_push);
    end
  end

  // D channel built from the FIFO heads; fields are zero when not valid.
  always_comb begin
    tl_o = '0;
    if (w_d_valid) begin
      tl_o[67]    = 1'b1;
      tl_o[66:64] = (w_hd_op == OP_GET) ? ACKD : ACK;
      tl_o[60:59] = w_hd[10:9];
      tl_o[58:51] = w_hd[8:1];
      tl_o[49:18] = (w_hd_read && !w_rsp_hd[32]) ? w_rsp_hd[31:0] : 32'h0;
      tl_o[1]     = w_hd_err | (w_hd_read & w_rsp_hd[32]);
    end
    tl_o[0] = w_a_ready;
  end

endmodule

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 SHALL have parameter SramAw, default 12, meaning the SRAM word-address width.
REQ-002 SHALL have parameter Outstanding, default 2, meaning the maximum number of accepted requests not yet answered on D (2..4).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port tl_i, input, 102, the TL-UL host-to-device bundle:
- a_valid [101]
- a_opcode [100:98]
- a_param [97:95]
- a_size [94:93]
- a_source [92:85]
- a_address [84:53]
- a_mask [52:49]
- a_data [48:17]
- a_user [16:1]
- d_ready [0]
REQ-006 SHALL have port tl_o, output, 68, the TL-UL device-to-host bundle:
- d_valid [67]
- d_opcode [66:64]
- d_param [63:61]
- d_size [60:59]
- d_source [58:51]
- d_sink [50]
- d_data [49:18]
- d_user [17:2]
- d_error [1]
- a_ready [0]
REQ-007 SHALL have port req_o, output, 1, SRAM request.
REQ-008 SHALL have port gnt_i, input, 1, SRAM grant.
REQ-009 SHALL have port we_o, output, 1, SRAM write enable.
REQ-010 SHALL have port addr_o, output, SramAw, SRAM word address, equal to a_address[SramAw+1:2].
REQ-011 SHALL have port wdata_o, output, 32, write data, equal to a_data.
REQ-012 SHALL have port wmask_o, output, 32, bit mask in which each a_mask bit is replicated 8 times.
REQ-013 SHALL have port rvalid_i, input, 1, SRAM read data valid; read data returns in order, at least 1 cycle after the grant.
REQ-014 SHALL have port rdata_i, input, 32, SRAM read data.
REQ-015 SHALL have port rerror_i, input, 2, SRAM read error; any set bit means an uncorrectable error.

Function
REQ-016 Opcode encodings SHALL be: Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1.
REQ-017 A request SHALL be flagged in error when any of the following holds:
- opcode is not in {0, 1, 4};
- a_size > 2;
- address is misaligned for a_size (size 1: a_address[0]!=0; size 2: a_address[1:0]!=0);
- opcode is PutFullData and a_mask is not all-ones over the size-aligned lanes.
REQ-018 Error requests SHALL NOT assert req_o; they are accepted when reqfifo is not full.
REQ-019 req_o SHALL equal a_valid AND NOT error AND reqfifo-not-full.
REQ-020 a_ready SHALL equal reqfifo-not-full AND (error OR gnt_i).
REQ-021 A request SHALL be accepted in any cycle with a_valid AND a_ready; each acceptance pushes {opcode, size, source, error} into reqfifo (depth Outstanding).
REQ-022 we_o SHALL be 1 for PutFullData and PutPartialData and 0 for Get.
REQ-023 Each rvalid_i SHALL push {rdata_i, |rerror_i} into rspfifo (depth Outstanding). rspfifo cannot overflow because read grants are bounded by reqfifo occupancy. An rvalid_i while no granted read is pending SHALL be ignored.
REQ-024 d_valid SHALL be asserted when reqfifo is non-empty and either:
- the head entry is a write, or
- the head entry is in error, or
- the head entry is a read and rspfifo is non-empty.
REQ-025 D fields SHALL be driven from the reqfifo head (and the rspfifo head for reads):
- d_opcode = AccessAckData for Get, otherwise AccessAck.
- d_size and d_source echo the request.
- d_param = 0, d_sink = 0, d_user = 0.
- d_data = rdata for a non-error read, otherwise 0.
- d_error = request error OR stored rerror.
REQ-026 On d_valid AND d_ready the reqfifo head SHALL pop; for reads the rspfifo head SHALL also pop in the same cycle.
REQ-027 D outputs SHALL hold stable while d_valid=1 and d_ready=0.
REQ-028 Minimum latency SHALL be 1 cycle: acceptance in cycle N gives d_valid at earliest in cycle N+1 (writes/errors); a read gives d_valid in the cycle after rvalid_i.
REQ-029 Pop and push in the same cycle SHALL be supported on both FIFOs; a full reqfifo with a simultaneous pop SHALL still hold a_ready=0 that cycle (no fall-through on full).
REQ-030 Responses SHALL be returned strictly in acceptance order.
REQ-031 FIFO pointers SHALL wrap modulo Outstanding; occupancy counters SHALL be clog2(Outstanding+1) bits wide.

Reset
REQ-032 While rst_ni=0, both FIFOs SHALL be empty, d_valid=0, and all registered D fields SHALL be 0.
REQ-033 Requests in flight at reset assertion SHALL be discarded; no D response is produced for them after reset release.
REQ-034 Any rvalid_i received after reset release for a pre-reset grant SHALL be dropped (REQ-023).

Verification
REQ-035 Write: Put (opcode 0, size 2, addr 0x40, mask 0xF, data 0xDEADBEEF, source 0x12), gnt_i=1 -> in the acceptance cycle req_o=1, we_o=1, addr_o=0x010, wmask_o=0xFFFFFFFF; next cycle d_valid=1, d_opcode=0, d_source=0x12, d_error=0.
REQ-036 Read: Get addr 0x44 granted, rvalid_i 2 cycles later with rdata_i 0xCAFEF00D -> d_opcode=1, d_data=0xCAFEF00D, in the cycle after rvalid_i.
REQ-037 Error: Get size 2 at addr 0x42 -> req_o stays 0, a_ready=1, next cycle d_error=1, d_data=0; same for opcode 3.
REQ-038 Backpressure: d_ready=0 with Outstanding=2:
- after 2 accepted writes, a_ready=0 and D fields stay stable;
- raising d_ready drains both responses in order with sources 1 then 2.
REQ-039 Read error: rerror_i=2'b10 with rvalid_i -> d_error=1, d_opcode=1.
REQ-040 Reset mid-read: assert rst_ni=0 after a read is granted and before rvalid_i -> d_valid=0 after release, and a late rvalid_i produces no response.
